// File: rtl/seq_comparator_if.sv
// Handshake and operand/result bundle for seq_comparator.
// The master drives the start request and the operands.
// The slave (the comparator) drives the status and result flags.
interface seq_comparator_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             Equality;
    logic             A_greater;
    logic             B_greater;

    modport master (
        output start, A, B,
        input  busy, done, Equality, A_greater, B_greater
    );

    modport slave (
        input  start, A, B,
        output busy, done, Equality, A_greater, B_greater
    );
endinterface

// File: rtl/seq_comparator.sv
// Bit-serial, MSB-first magnitude comparator with a start/done handshake.
// EARLY_EXIT = 1 stops at the first differing bit. EARLY_EXIT = 0 always walks all
// WIDTH bits, so latency is constant.
// Optional macro SIGNED_CMP_EN selects a two's-complement comparison by inverting the
// sense of the sign bit. When the macro is undefined, no sign logic is built.
// Results hold until the next entry to DONE or until reset.
module seq_comparator #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned EARLY_EXIT = 1
) (
    input logic               clk,
    input logic               reset,
    seq_comparator_if.slave   bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StCompare, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              found_q, found_d;   // a difference has already been latched
    logic              a_win_q, a_win_d;   // sticky winner; valid while found_q
    logic              eq_q, eq_d;
    logic              agt_q, agt_d;
    logic              bgt_q, bgt_d;

    logic a_msb, b_msb, differ, a_wins, last_bit, new_diff;

    // Per-bit decision at the current MSB of the shift registers
    always_comb begin
        a_msb    = a_sh_q[WIDTH-1];
        b_msb    = b_sh_q[WIDTH-1];
        differ   = a_msb ^ b_msb;
        last_bit = (cnt_q == CntW'(WIDTH - 1));
        new_diff = differ & ~found_q;
`ifdef SIGNED_CMP_EN
        // At the sign bit, a 0 beats a 1
        a_wins = (cnt_q == '0) ? (~a_msb & b_msb) : (a_msb & ~b_msb);
`else
        a_wins = a_msb & ~b_msb;
`endif
    end

    // Next-state, datapath and result update
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        cnt_d   = cnt_q;
        found_d = found_q;
        a_win_d = a_win_q;
        eq_d    = eq_q;
        agt_d   = agt_q;
        bgt_d   = bgt_q;

        case (state_q)
            StIdle, StDone: begin
                // start in DONE takes priority over returning to IDLE
                if (bus.start) begin
                    a_sh_d  = bus.A;
                    b_sh_d  = bus.B;
                    cnt_d   = '0;
                    found_d = 1'b0;
                    a_win_d = 1'b0;
                    state_d = StCompare;
                end else begin
                    state_d = StIdle;
                end
            end
            StCompare: begin
                if (new_diff) begin
                    found_d = 1'b1;
                    a_win_d = a_wins;
                end
                if ((new_diff && (EARLY_EXIT != 0)) || last_bit) begin
                    state_d = StDone;
                    eq_d    = ~found_d;
                    agt_d   = found_d & a_win_d;
                    bgt_d   = found_d & ~a_win_d;
                end else begin
                    a_sh_d = {a_sh_q[WIDTH-2:0], 1'b0};
                    b_sh_d = {b_sh_q[WIDTH-2:0], 1'b0};
                    cnt_d  = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            cnt_q   <= '0;
            found_q <= 1'b0;
            a_win_q <= 1'b0;
            eq_q    <= 1'b0;
            agt_q   <= 1'b0;
            bgt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            cnt_q   <= cnt_d;
            found_q <= found_d;
            a_win_q <= a_win_d;
            eq_q    <= eq_d;
            agt_q   <= agt_d;
            bgt_q   <= bgt_d;
        end
    end

    // Status decoded from state; results come straight from registers
    always_comb begin
        bus.busy      = (state_q == StCompare);
        bus.done      = (state_q == StDone);
        bus.Equality  = eq_q;
        bus.A_greater = agt_q;
        bus.B_greater = bgt_q;
    end
endmodule

// File: tb/tb_seq_comparator.sv
// Directed bench for seq_comparator, WIDTH = 8.
// dut1 uses EARLY_EXIT = 1 and dut0 uses EARLY_EXIT = 0.
// Result flags are checked packed as {Equality, A_greater, B_greater}.
// Latency is counted as the cycle in which done is high, with the start cycle as cycle 0.
module tb_seq_comparator;
    logic clk = 1'b0;
    logic reset;
    int   n_pass = 0;
    int   n_total = 0;
    int   lat;

    always #5 clk = ~clk;

    seq_comparator_if #(.WIDTH(8)) bus0 ();
    seq_comparator_if #(.WIDTH(8)) bus1 ();

    seq_comparator #(.WIDTH(8), .EARLY_EXIT(0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
    seq_comparator #(.WIDTH(8), .EARLY_EXIT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [2:0] res(input bit sel);
        if (sel) return {bus1.Equality, bus1.A_greater, bus1.B_greater};
        return {bus0.Equality, bus0.A_greater, bus0.B_greater};
    endfunction

    // Drive start for one cycle; returns in cycle 1 of the comparison
    task automatic launch(input bit sel, input logic [7:0] a, input logic [7:0] b);
        if (sel) begin
            bus1.A = a; bus1.B = b; bus1.start = 1'b1;
        end else begin
            bus0.A = a; bus0.B = b; bus0.start = 1'b1;
        end
        step();
        bus0.start = 1'b0;
        bus1.start = 1'b0;
    endtask

    // Advance until done, bounded; lat is the cycle number done was seen in
    task automatic wait_done(input bit sel, input int from, output int l);
        l = from;
        while (!(sel ? bus1.done : bus0.done) && l < 40) begin
            step();
            l++;
        end
    endtask

    initial begin
        bus0.start = 1'b0; bus0.A = '0; bus0.B = '0;
        bus1.start = 1'b0; bus1.A = '0; bus1.B = '0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("reset_busy", bus1.busy, 0);
        chk("reset_done", bus1.done, 0);
        chk("reset_res", res(1), 3'b000);
        chk("reset_res0", res(0), 3'b000);

        // 1: MSB differs, early exit after one compare cycle
        launch(1, 8'hC0, 8'h40);
        chk("s1_busy_c1", bus1.busy, 1);
        chk("s1_done_c1", bus1.done, 0);
        wait_done(1, 1, lat);
        chk("s1_latency", lat, 2);
        chk("s1_busy_c2", bus1.busy, 0);
        chk("s1_res", res(1), 3'b010);
        step();
        chk("s1_done_c3", bus1.done, 0);
        chk("s1_hold_idle", res(1), 3'b010);

        // 2: first difference at bit 3 -> N = 5
        launch(1, 8'h03, 8'h0A);
        chk("s2_hold_busy", res(1), 3'b010);
        wait_done(1, 1, lat);
        chk("s2_latency", lat, 6);
        chk("s2_res", res(1), 3'b001);
        step();

        // 3: equal operands, then back-to-back start from DONE
        launch(1, 8'h77, 8'h77);
        wait_done(1, 1, lat);
        chk("s3_latency", lat, 9);
        chk("s3_res", res(1), 3'b100);
        launch(1, 8'h00, 8'h01);
        chk("s3_b2b_busy", bus1.busy, 1);
        chk("s3_b2b_hold", res(1), 3'b100);
        wait_done(1, 1, lat);
        // differ at bit 0: compare in cycles 1..8, done in cycle 9
        chk("s3_b2b_latency", lat, 9);
        chk("s3_b2b_res", res(1), 3'b001);
        step();

        // 4a: start during COMPARE is ignored
        launch(1, 8'h10, 8'h20);
        bus1.A = 8'hFF; bus1.B = 8'h00; bus1.start = 1'b1;
        step();
        bus1.start = 1'b0;
        wait_done(1, 2, lat);
        chk("s4_latency", lat, 4);
        chk("s4_res", res(1), 3'b001);
        step();
        chk("s4_idle_busy", bus1.busy, 0);
        chk("s4_idle_done", bus1.done, 0);

        // 4b: reset in cycle 3, with start also asserted
        launch(1, 8'h01, 8'h01);
        step();
        step();
        reset = 1'b1; bus1.start = 1'b1; bus1.A = 8'hF0;
        step();
        reset = 1'b0; bus1.start = 1'b0;
        chk("s4_rst_busy", bus1.busy, 0);
        chk("s4_rst_done", bus1.done, 0);
        chk("s4_rst_res", res(1), 3'b000);
        step();
        chk("s4_rst_nostart", bus1.busy, 0);

        // 5: sign bit handling
        launch(1, 8'h80, 8'h01);
        wait_done(1, 1, lat);
        chk("s5_latency", lat, 2);
`ifdef SIGNED_CMP_EN
        chk("s5_res", res(1), 3'b001);
`else
        chk("s5_res", res(1), 3'b010);
`endif
        step();

        // 6: constant latency with sticky decision
        launch(0, 8'hC0, 8'h40);
        step(); step(); step(); step();
        chk("s6_busy_c5", bus0.busy, 1);
        chk("s6_nores_c5", res(0), 3'b000);
        wait_done(0, 5, lat);
        chk("s6_latency", lat, 9);
        chk("s6_res", res(0), 3'b010);
        // MSB decides; every later bit favours the other operand
        launch(0, 8'h80, 8'h7F);
        wait_done(0, 1, lat);
        chk("s6_sticky_latency", lat, 9);
`ifdef SIGNED_CMP_EN
        chk("s6_sticky_res", res(0), 3'b001);
`else
        chk("s6_sticky_res", res(0), 3'b010);
`endif
        step();
        launch(0, 8'h3C, 8'h3C);
        wait_done(0, 1, lat);
        chk("s6_eq_latency", lat, 9);
        chk("s6_eq_res", res(0), 3'b100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
